// File: rtl/wb_queue.sv
// In-order writeback queue feeding the register-file write port, with youngest-entry rs forwarding.
// Latency 1+ cycles (wb_hold stalls drain); in_ready = !full. WB_COALESCE_EN merges same-rd pushes into the youngest entry.
module wb_queue #(
  parameter int w     = 9,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [1:0]                 in_rd,
  input  logic [w-1:0]               in_data,
  input  logic                       wb_hold,
  output logic                       wr_en,
  output logic [1:0]                 wr_rd_addr,
  output logic [w-1:0]               wr_data,
  input  logic [3:0]                 rs_addr,
  output logic                       rs_fwd_hit,
  output logic [w-1:0]               rs_fwd_data,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       empty,
  output logic                       full
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH+1);

  logic [DEPTH-1:0] ent_vld;
  logic [1:0]       ent_rd  [DEPTH];
  logic [w-1:0]     ent_dat [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic             push;
  logic             pop;
  logic             alloc;
  logic             coalesce;

  assign empty      = (count == '0);
  assign full       = (count == CW'(DEPTH));
  assign wr_en      = !empty && !wb_hold;
  assign wr_rd_addr = ent_rd[rd_ptr];
  assign wr_data    = ent_dat[rd_ptr];
  assign pop        = wr_en;
  assign push       = in_valid && in_ready;
  assign alloc      = push && !coalesce;

`ifdef WB_COALESCE_EN
  logic [AW-1:0] y_idx;
  logic          coal_match;

  assign y_idx      = wr_ptr - AW'(1);
  assign coal_match = !empty && (ent_rd[y_idx] == in_rd);
  assign in_ready   = !full || coal_match;
  // The youngest entry leaving this cycle cannot absorb the push; allocate instead.
  assign coalesce   = push && coal_match && !(pop && (count == CW'(1)));
`else
  assign in_ready   = !full;
  assign coalesce   = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count   <= '0;
      ent_vld <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        ent_rd[i]  <= '0;
        ent_dat[i] <= '0;
      end
    end else begin
      if (pop) begin
        ent_vld[rd_ptr] <= 1'b0;
        rd_ptr          <= rd_ptr + AW'(1);
      end
      if (alloc) begin
        ent_vld[wr_ptr] <= 1'b1;
        ent_rd[wr_ptr]  <= in_rd;
        ent_dat[wr_ptr] <= in_data;
        wr_ptr          <= wr_ptr + AW'(1);
      end
`ifdef WB_COALESCE_EN
      if (coalesce) begin
        ent_dat[y_idx] <= in_data;
      end
`endif
      case ({alloc, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Scan oldest to youngest so the last match wins; popping entries still forward.
  always_comb begin
    logic [AW-1:0] f_idx;
    rs_fwd_hit  = 1'b0;
    rs_fwd_data = '0;
    f_idx       = '0;
    for (int i = 0; i < DEPTH; i++) begin
      f_idx = rd_ptr + AW'(i);
      if (ent_vld[f_idx] && ((4'd8 + {2'b00, ent_rd[f_idx]}) == rs_addr)) begin
        rs_fwd_hit  = 1'b1;
        rs_fwd_data = ent_dat[f_idx];
      end
    end
  end

endmodule

// File: tb/tb_wb_queue.sv
// Directed bench for wb_queue (DEPTH=2, w=9); expectations follow WB_COALESCE_EN when defined.
module tb_wb_queue;

  localparam int W     = 9;
  localparam int DEPTH = 2;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [1:0]   in_rd;
  logic [W-1:0] in_data;
  logic         wb_hold;
  logic         wr_en;
  logic [1:0]   wr_rd_addr;
  logic [W-1:0] wr_data;
  logic [3:0]   rs_addr;
  logic         rs_fwd_hit;
  logic [W-1:0] rs_fwd_data;
  logic [1:0]   count;
  logic         empty;
  logic         full;

  int n_chk  = 0;
  int n_fail = 0;

  wb_queue #(.w(W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_rd(in_rd), .in_data(in_data),
    .wb_hold(wb_hold),
    .wr_en(wr_en), .wr_rd_addr(wr_rd_addr), .wr_data(wr_data),
    .rs_addr(rs_addr), .rs_fwd_hit(rs_fwd_hit), .rs_fwd_data(rs_fwd_data),
    .count(count), .empty(empty), .full(full)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance past the next rising edge; inputs change and outputs are sampled 1ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_drive(input logic [1:0] rd, input logic [W-1:0] d);
    in_valid = 1'b1;
    in_rd    = rd;
    in_data  = d;
  endtask

  task automatic drain();
    wb_hold  = 1'b0;
    in_valid = 1'b0;
    #1;
    for (int i = 0; i < 8; i++) begin
      if (empty) break;
      tick();
    end
    chk("drain_empty", 32'(empty), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_rd = 2'd0; in_data = '0; wb_hold = 1'b0; rs_addr = 4'd0;
    #2;
    chk("rst_wr_en",    32'(wr_en),       32'd0);
    chk("rst_count",    32'(count),       32'd0);
    chk("rst_empty",    32'(empty),       32'd1);
    chk("rst_full",     32'(full),        32'd0);
    chk("rst_in_ready", 32'(in_ready),    32'd1);
    chk("rst_fwd_hit",  32'(rs_fwd_hit),  32'd0);
    chk("rst_fwd_data", 32'(rs_fwd_data), 32'd0);
    tick();
    rst_n = 1'b1;

    // Reset mid-run discards the pending rd=1 entry.
    wb_hold = 1'b1;
    push_drive(2'd1, 9'h0AA);
    tick();
    in_valid = 1'b0;
    chk("mid_count_pre", 32'(count), 32'd1);
    rs_addr = 4'd9;
    #1;
    chk("mid_fwd_pre", 32'(rs_fwd_hit), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_wr_en",    32'(wr_en),      32'd0);
    chk("mid_count",    32'(count),      32'd0);
    chk("mid_empty",    32'(empty),      32'd1);
    chk("mid_in_ready", 32'(in_ready),   32'd1);
    chk("mid_fwd_hit",  32'(rs_fwd_hit), 32'd0);
    rst_n   = 1'b1;
    wb_hold = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("mid_no_write", 32'(wr_en), 32'd0);
    end

    // Basic path.
    push_drive(2'd2, 9'h155);
    #1;
    chk("basic_pre_wr_en", 32'(wr_en), 32'd0);
    tick();
    in_valid = 1'b0;
    chk("basic_wr_en",   32'(wr_en),      32'd1);
    chk("basic_wr_addr", 32'(wr_rd_addr), 32'd2);
    chk("basic_wr_data", 32'(wr_data),    32'h155);
    chk("basic_count1",  32'(count),      32'd1);
    tick();
    chk("basic_count0",  32'(count),      32'd0);
    chk("basic_wr_en0",  32'(wr_en),      32'd0);

    // Fill and back-pressure.
    wb_hold = 1'b1;
    push_drive(2'd0, 9'h001);
    tick();
    push_drive(2'd3, 9'h1FF);
    tick();
    in_valid = 1'b0;
    in_rd    = 2'd1;
    #1;
    chk("fill_full",     32'(full),     32'd1);
    chk("fill_in_ready", 32'(in_ready), 32'd0);
    chk("fill_count",    32'(count),    32'd2);
    chk("fill_hold_wr",  32'(wr_en),    32'd0);
    wb_hold = 1'b0;
    #1;
    chk("fill_wr0_en",   32'(wr_en),      32'd1);
    chk("fill_wr0_addr", 32'(wr_rd_addr), 32'd0);
    chk("fill_wr0_data", 32'(wr_data),    32'h001);
    tick();
    chk("fill_wr1_addr", 32'(wr_rd_addr), 32'd3);
    chk("fill_wr1_data", 32'(wr_data),    32'h1FF);
    chk("fill_count1",   32'(count),      32'd1);
    tick();
    chk("fill_empty",    32'(empty),      32'd1);

    // Simultaneous push and pop with one entry resident.
    push_drive(2'd1, 9'h011);
    tick();
    for (int k = 0; k < 4; k++) begin
      logic [1:0]   exp_rd;
      logic [W-1:0] exp_d;
      exp_rd = (k == 0) ? 2'd1 : 2'((k + 1) % 4);
      exp_d  = (k == 0) ? 9'h011 : 9'(9'h020 + k - 1);
      push_drive(2'((k + 2) % 4), 9'(9'h020 + k));
      #1;
      chk("sim_count",   32'(count),      32'd1);
      chk("sim_wr_en",   32'(wr_en),      32'd1);
      chk("sim_wr_addr", 32'(wr_rd_addr), 32'(exp_rd));
      chk("sim_wr_data", 32'(wr_data),    32'(exp_d));
      tick();
    end
    in_valid = 1'b0;
    #1;
    chk("sim_last_data", 32'(wr_data),    32'h023);
    chk("sim_last_addr", 32'(wr_rd_addr), 32'd1);
    tick();
    chk("sim_empty", 32'(empty), 32'd1);

    // Forwarding picks the youngest match.
    wb_hold = 1'b1;
    push_drive(2'd1, 9'h010);
    tick();
    push_drive(2'd1, 9'h020);
    tick();
    in_valid = 1'b0;
    in_rd    = 2'd0;
`ifdef WB_COALESCE_EN
    chk("fwd_count", 32'(count), 32'd1);
`else
    chk("fwd_count", 32'(count), 32'd2);
`endif
    rs_addr = 4'd9;
    #1;
    chk("fwd9_hit",  32'(rs_fwd_hit),  32'd1);
    chk("fwd9_data", 32'(rs_fwd_data), 32'h020);
    rs_addr = 4'd5;
    #1;
    chk("fwd5_hit",  32'(rs_fwd_hit),  32'd0);
    chk("fwd5_data", 32'(rs_fwd_data), 32'd0);
    rs_addr = 4'd13;
    #1;
    chk("fwd13_hit", 32'(rs_fwd_hit),  32'd0);
    rs_addr = 4'd8;
    #1;
    chk("fwd8_hit",  32'(rs_fwd_hit),  32'd0);
    rs_addr = 4'd9;
    wb_hold = 1'b0;
    #1;
    chk("fwd_pop_hit",  32'(rs_fwd_hit),  32'd1);
    chk("fwd_pop_data", 32'(rs_fwd_data), 32'h020);
    drain();
    chk("fwd_gone_hit", 32'(rs_fwd_hit), 32'd0);

    // Same-rd pushes: coalesce or allocate.
    wb_hold = 1'b1;
    push_drive(2'd2, 9'h003);
    tick();
    push_drive(2'd2, 9'h004);
    tick();
    in_valid = 1'b0;
    in_rd    = 2'd0;
    wb_hold  = 1'b0;
    #1;
`ifdef WB_COALESCE_EN
    chk("coal_count", 32'(count),   32'd1);
    chk("coal_data",  32'(wr_data), 32'h004);
    tick();
    chk("coal_empty", 32'(empty),   32'd1);
`else
    chk("coal_count", 32'(count),   32'd2);
    chk("coal_data0", 32'(wr_data), 32'h003);
    tick();
    chk("coal_data1", 32'(wr_data), 32'h004);
    chk("coal_addr1", 32'(wr_rd_addr), 32'd2);
    tick();
    chk("coal_empty", 32'(empty),   32'd1);
`endif

    $display("[TB] %0d tests run, %0d failed", n_chk, n_fail);
    $finish;
  end

endmodule
